reaction_trial_sched: RTL and testbench

Controller that sequences one reaction-time trial on the board. It arms a random-length wait, fires the GO indication, and drives the clear and enable inputs of the millisecond BCD counter. It latches the reaction time, tracks the session best, and selects what the six-digit display shows. It sits between the debounced KEY pulses, the LFSR, the 1 ms tick, the binary view of the counter, and the display mux.

---
 rtl/reaction_trial_sched_if.sv | 36 +++
 rtl/reaction_trial_sched.sv | 146 ++++++++++++++
 tb/tb_reaction_trial_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_trial_sched_if.sv
// ============================================================================
// reaction_trial_sched_if : trial-controller signal bundle (tick/keys/LFSR/counter in, display/status out)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reaction_trial_sched_if;
  logic        ms_tick;
  logic        start_p;
  logic        stop_p;
  logic        clear_best;
  logic        show_best;
  logic [14:0] rand_num;
  logic [19:0] elapsed_ms;
  logic        cnt_clear;
  logic        cnt_en;
  logic        led_go;
  logic [2:0]  state;
  logic [19:0] result_ms;
  logic [19:0] best_ms;
  logic        timed_out;
  logic [6:0]  trials;
  logic [1:0]  disp_sel;

  modport slave (
    input  ms_tick, start_p, stop_p, clear_best, show_best, rand_num, elapsed_ms,
    output cnt_clear, cnt_en, led_go, state, result_ms, best_ms, timed_out, trials, disp_sel
  );

  modport master (
    output ms_tick, start_p, stop_p, clear_best, show_best, rand_num, elapsed_ms,
    input  cnt_clear, cnt_en, led_go, state, result_ms, best_ms, timed_out, trials, disp_sel
  );
endinterface

`default_nettype wire

// File: rtl/reaction_trial_sched.sv
// ============================================================================
// reaction_trial_sched : sequences one reaction-time trial, latches result/best
// Revision: 1.0
// ============================================================================
`default_nettype none

module reaction_trial_sched #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 12,
  parameter int TIMEOUT_MS   = 9999,
  parameter int DLY_W        = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  reaction_trial_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_FOUL   = 3'd4
  } state_t;

  localparam logic [19:0]      NO_BEST     = 20'hFFFFF;
  localparam logic [19:0]      TIMEOUT_VAL = 20'(TIMEOUT_MS);
  localparam logic [DLY_W-1:0] MIN_DLY     = DLY_W'(MIN_DELAY_MS);

  state_t           state_q, state_d;
  logic [DLY_W-1:0] wait_q, wait_d;
  logic [19:0]      result_q, result_d;
  logic [19:0]      best_q, best_d;
  logic             timed_out_q, timed_out_d;
  logic [6:0]       trials_q, trials_d;
  logic             cnt_clear_q, cnt_clear_d;
  logic             cnt_en_q, cnt_en_d;
  logic             led_go_q, led_go_d;
  logic [1:0]       disp_sel_q, disp_sel_d;
  logic [DLY_W-1:0] load_val;

  assign load_val = MIN_DLY + DLY_W'(bus.rand_num[RAND_BITS-1:0]);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    result_d    = result_q;
    best_d      = best_q;
    timed_out_d = timed_out_q;
    trials_d    = trials_q;

    case (state_q)
      S_IDLE: begin
        if (bus.clear_best) best_d = NO_BEST;
        if (bus.start_p) begin
          state_d = S_ARM;
          wait_d  = load_val;
        end
      end
      S_ARM: begin
        // A reaction key during the wait is a foul even on the final tick.
        if (bus.stop_p) begin
          state_d = S_FOUL;
        end else if (bus.ms_tick) begin
          if (wait_q == DLY_W'(1)) state_d = S_GO;
          if (wait_q != '0)        wait_d  = wait_q - DLY_W'(1);
        end
      end
      S_GO: begin
        if (bus.stop_p) begin
          state_d     = S_RESULT;
          result_d    = bus.elapsed_ms;
          timed_out_d = 1'b0;
          if (bus.elapsed_ms < best_q) best_d = bus.elapsed_ms;
          trials_d    = (trials_q == 7'd99) ? 7'd0 : trials_q + 7'd1;
        end else if (bus.elapsed_ms >= TIMEOUT_VAL) begin
          state_d     = S_RESULT;
          result_d    = TIMEOUT_VAL;
          timed_out_d = 1'b1;
        end
      end
      S_RESULT, S_FOUL: begin
        if (bus.start_p) begin
          state_d = S_ARM;
          wait_d  = load_val;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they land with the transition.
    cnt_clear_d = (state_d != state_q) && ((state_d == S_ARM) || (state_d == S_GO));
    cnt_en_d    = (state_d == S_GO);
    led_go_d    = (state_d == S_GO);

    case (state_d)
      S_IDLE:   disp_sel_d = (best_d != NO_BEST) ? 2'd2 : 2'd0;
      S_RESULT: disp_sel_d = bus.show_best ? 2'd2 : 2'd1;
      S_FOUL:   disp_sel_d = 2'd3;
      default:  disp_sel_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      result_q    <= '0;
      best_q      <= NO_BEST;
      timed_out_q <= 1'b0;
      trials_q    <= '0;
      cnt_clear_q <= 1'b0;
      cnt_en_q    <= 1'b0;
      led_go_q    <= 1'b0;
      disp_sel_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      result_q    <= result_d;
      best_q      <= best_d;
      timed_out_q <= timed_out_d;
      trials_q    <= trials_d;
      cnt_clear_q <= cnt_clear_d;
      cnt_en_q    <= cnt_en_d;
      led_go_q    <= led_go_d;
      disp_sel_q  <= disp_sel_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.result_ms = result_q;
  assign bus.best_ms   = best_q;
  assign bus.timed_out = timed_out_q;
  assign bus.trials    = trials_q;
  assign bus.cnt_clear = cnt_clear_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.led_go    = led_go_q;
  assign bus.disp_sel  = disp_sel_q;

  // Only the low RAND_BITS of the LFSR set the delay.
  logic unused_rand;
  assign unused_rand = ^bus.rand_num[14:RAND_BITS];

endmodule

`default_nettype wire

// File: tb/tb_reaction_trial_sched.sv
// ============================================================================
// tb_reaction_trial_sched : directed/randomized bench with a trial-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reaction_trial_sched;

  localparam int ST_IDLE = 0, ST_ARM = 1, ST_GO = 2, ST_RESULT = 3, ST_FOUL = 4;
  localparam logic [19:0] NONE = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        reset, ms_tick, start_p, stop_p, clear_best, show_best;
  logic [14:0] rand_num;
  logic [19:0] elapsed_ms;

  always #50 clk = ~clk;

  reaction_trial_sched_if bus_a ();
  reaction_trial_sched_if bus_f ();

  assign bus_a.ms_tick = ms_tick;       assign bus_f.ms_tick = ms_tick;
  assign bus_a.start_p = start_p;       assign bus_f.start_p = start_p;
  assign bus_a.stop_p = stop_p;         assign bus_f.stop_p = stop_p;
  assign bus_a.clear_best = clear_best; assign bus_f.clear_best = clear_best;
  assign bus_a.show_best = show_best;   assign bus_f.show_best = show_best;
  assign bus_a.rand_num = rand_num;     assign bus_f.rand_num = rand_num;
  assign bus_a.elapsed_ms = elapsed_ms; assign bus_f.elapsed_ms = elapsed_ms;

  reaction_trial_sched u_dut (.clk(clk), .reset(reset), .bus(bus_a));

  // Short-delay instance so a hundred valid trials fit in a small run.
  reaction_trial_sched #(.MIN_DELAY_MS(2), .RAND_BITS(2), .TIMEOUT_MS(9999), .DLY_W(4))
    u_dut_fast (.clk(clk), .reset(reset), .bus(bus_f));

  int          n_checks = 0;
  int          n_err    = 0;
  int          m_state, m_trials, m_wait;
  logic [19:0] m_result, m_best;
  logic        m_to;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_disp();
    case (m_state)
      ST_IDLE:   return (m_best != NONE) ? 2 : 0;
      ST_RESULT: return show_best ? 2 : 1;
      ST_FOUL:   return 3;
      default:   return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_result = '0; m_best = NONE; m_to = 1'b0; m_trials = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " state"},     32'(bus_a.state),     32'(m_state));
    chk({tag, " result"},    32'(bus_a.result_ms), 32'(m_result));
    chk({tag, " best"},      32'(bus_a.best_ms),   32'(m_best));
    chk({tag, " trials"},    32'(bus_a.trials),    32'(m_trials));
    chk({tag, " timed_out"}, 32'(bus_a.timed_out), 32'(m_to));
    chk({tag, " disp_sel"},  32'(bus_a.disp_sel),  32'(exp_disp()));
    chk({tag, " led_go"},    32'(bus_a.led_go),    32'(m_state == ST_GO));
    chk({tag, " cnt_en"},    32'(bus_a.cnt_en),    32'(m_state == ST_GO));
  endtask

  task automatic do_start(input logic [14:0] r);
    rand_num   = r;
    elapsed_ms = '0;
    start_p    = 1'b1;
    step();
    start_p    = 1'b0;
    m_state    = ST_ARM;
    m_wait     = 1000 + int'(r[11:0]);
    chk("arm entry clear", 32'(bus_a.cnt_clear), 32'd1);
    check_all("arm entry");
  endtask

  // Deliver n ticks in ARM; returns how many cycles showed clear/led/non-ARM.
  task automatic arm_ticks(input int n, output int odd);
    odd = 0;
    for (int i = 0; i < n; i++) begin
      ms_tick = 1'b1;
      step();
      ms_tick = 1'b0;
      odd += int'(bus_a.cnt_clear) + int'(bus_a.led_go) + int'(bus_a.state != 3'(ST_ARM));
      if ($urandom_range(0, 15) == 0) begin
        step();
        odd += int'(bus_a.cnt_clear) + int'(bus_a.led_go) + int'(bus_a.state != 3'(ST_ARM));
      end
    end
  endtask

  task automatic arm_to_go();
    int odd;
    arm_ticks(m_wait - 1, odd);
    chk("arm hold", 32'(odd), 32'd0);
    ms_tick = 1'b1;
    step();
    ms_tick = 1'b0;
    m_state = ST_GO;
    chk("go entry clear", 32'(bus_a.cnt_clear), 32'd1);
    check_all("go entry");
    step();
    chk("go clear single", 32'(bus_a.cnt_clear), 32'd0);
    chk("go hold", 32'(bus_a.state), 32'(ST_GO));
  endtask

  task automatic go_stop(input logic [19:0] e, input logic tick);
    elapsed_ms = e;
    stop_p     = 1'b1;
    ms_tick    = tick;
    step();
    stop_p     = 1'b0;
    ms_tick    = 1'b0;
    m_state    = ST_RESULT;
    m_result   = e;
    m_to       = 1'b0;
    if (e < m_best) m_best = e;
    m_trials   = (m_trials + 1) % 100;
    check_all("stop");
    chk("stop no clear", 32'(bus_a.cnt_clear), 32'd0);
  endtask

  initial begin
    int          odd, f_trials, f_wait;
    logic [19:0] f_best, e;
    logic [14:0] r;

    reset = 1'b1; ms_tick = 1'b0; start_p = 1'b0; stop_p = 1'b0;
    clear_best = 1'b0; show_best = 1'b0; rand_num = '0; elapsed_ms = '0;
    repeat (3) step();
    reset = 1'b0;
    model_reset();
    step();
    check_all("reset");
    chk("reset clear", 32'(bus_a.cnt_clear), 32'd0);

    // stop in IDLE is ignored
    stop_p = 1'b1; step(); stop_p = 1'b0;
    check_all("idle stop");

    // trial 1: rand low bits zero -> exactly 1000 ticks
    r = {3'($urandom_range(0, 7)), 12'd0};
    do_start(r);
    arm_to_go();
    start_p = 1'b1; step(); start_p = 1'b0;
    check_all("go start ignored");
    go_stop(20'd237, 1'b0);
    show_best = 1'b1; step();
    check_all("show best");
    show_best = 1'b0; step();
    check_all("show last");

    do_start(15'($urandom)); arm_to_go(); go_stop(20'd412, 1'b0);
    do_start(15'($urandom)); arm_to_go(); go_stop(20'd150, 1'b0);
    do_start(15'($urandom)); arm_to_go(); go_stop(20'($urandom_range(1, 9998)), 1'b0);

    // foul after 300 ticks
    do_start(15'($urandom));
    arm_ticks(300, odd);
    chk("foul pre ticks", 32'(odd), 32'd0);
    stop_p = 1'b1; step(); stop_p = 1'b0;
    m_state = ST_FOUL;
    check_all("foul early");

    // foul on the final tick
    do_start(15'($urandom));
    arm_ticks(m_wait - 1, odd);
    chk("foul late ticks", 32'(odd), 32'd0);
    stop_p = 1'b1; ms_tick = 1'b1; step(); stop_p = 1'b0; ms_tick = 1'b0;
    m_state = ST_FOUL;
    check_all("foul final tick");
    chk("foul no clear", 32'(bus_a.cnt_clear), 32'd0);

    // timeout
    do_start(15'($urandom)); arm_to_go();
    elapsed_ms = 20'd9998; step();
    check_all("pre timeout");
    elapsed_ms = 20'd9999; step();
    m_state = ST_RESULT; m_result = 20'd9999; m_to = 1'b1;
    check_all("timeout");

    // stop coincident with tick, and stop coincident with timeout
    do_start(15'($urandom)); arm_to_go(); go_stop(20'd500, 1'b1);
    do_start(15'($urandom)); arm_to_go(); go_stop(20'd9999, 1'b0);

    // clear_best outside IDLE is ignored
    clear_best = 1'b1; step(); clear_best = 1'b0;
    check_all("clear in result");

    // reset mid-GO
    do_start(15'($urandom)); arm_to_go();
    reset = 1'b1; step(); reset = 1'b0;
    model_reset();
    check_all("reset mid go");
    chk("reset mid go clear", 32'(bus_a.cnt_clear), 32'd0);

    clear_best = 1'b1; step(); step(); clear_best = 1'b0;
    check_all("clear in idle");

    // trials wrap on the short-delay instance
    reset = 1'b1; step(); reset = 1'b0; step();
    f_trials = 0; f_best = NONE;
    for (int t = 0; t < 100; t++) begin
      r = 15'($urandom);
      rand_num = r; elapsed_ms = '0;
      start_p = 1'b1; step(); start_p = 1'b0;
      f_wait = 2 + int'(r[1:0]);
      repeat (f_wait) begin
        ms_tick = 1'b1; step(); ms_tick = 1'b0;
      end
      chk("fast go", 32'(bus_f.state), 32'(ST_GO));
      e = 20'($urandom_range(0, 9998));
      elapsed_ms = e;
      stop_p = 1'b1; step(); stop_p = 1'b0;
      f_trials = (f_trials + 1) % 100;
      if (e < f_best) f_best = e;
      chk("fast trials", 32'(bus_f.trials), 32'(f_trials));
    end
    chk("fast wrap zero", 32'(bus_f.trials), 32'd0);
    chk("fast best", 32'(bus_f.best_ms), 32'(f_best));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
